add_result_checker: RTL and testbench
=====================================

// Module: add_result_checker
// PURPOSE
//  Receiving end of the adder stimulus path. It sits on the DUT output side and captures each
//  (a, b, out) vector the pattern source presents, then compares out against a reference a+b.
//  It keeps pass/fail tallies and the index of the first mismatch, then raises done after
//  NUM_VEC vectors, so adder runs self-check in sim/FPGA without waveform inspection.
// PARAMETERS
//  WIDTH    4  operand width; out/expected are WIDTH+1 bits (carry kept)
//  NUM_VEC  8  vectors checked per run
//  CNT_W    4  counter/index width; must satisfy 2**CNT_W > NUM_VEC
// PORTS
//  clk              in   1        single clock, rising edge
//  rst_n            in   1        asynchronous, active-low reset
//  start            in   1        1-cycle pulse: clear tallies, begin a run
//  in_valid         in   1        a/b/out hold a vector this cycle
//  in_ready         out  1        checker accepts a vector this cycle
//  a, b             in   WIDTH    operands the DUT was driven with
//  out              in   WIDTH+1  DUT sum under test
//  busy             out  1        run in progress
//  done             out  1        run complete; results stable
//  pass_cnt         out  CNT_W    vectors matching reference
//  fail_cnt         out  CNT_W    vectors mismatching reference
//  first_fail_vld   out  1        at least one mismatch this run
//  first_fail_idx   out  CNT_W    vector index (0-based) of first mismatch
//  all_pass         out  1        done && fail_cnt==0
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, every output 0, pipeline regs invalid.
//  - FSM IDLE->RUN on start; RUN->DONE when NUM_VEC accepted AND compare stage empty;
//    DONE->RUN on start. start in RUN restarts: tallies/index cleared, in-flight compare dropped.
//  - in_ready = (state==RUN) && (acc_idx < NUM_VEC) && !start. Accept = in_valid && in_ready.
//  - in_valid outside RUN is ignored: no count change, in_ready=0.
//  - Stage 1 (accept edge): register a, b, out, acc_idx; set cmp_vld; acc_idx++.
//  - Stage 2 (next edge): expected = {1'b0,a}+{1'b0,b} (WIDTH+1 bits, no truncation);
//    match -> pass_cnt++; else fail_cnt++, and if !first_fail_vld latch idx, set first_fail_vld.
//  - Latency: tallies reflect a vector 2 edges after its accept edge is sampled (1 edge later
//    than accept). done rises the edge after the last compare; busy = (state==RUN).
//  - Back-to-back accepts every cycle allowed; gaps in in_valid allowed, no timeout.
//  - done, tallies, first_fail_* hold in DONE until start or reset; all_pass combinational.
//  - X on out while in_valid=1 counts as fail (case-inequality not used in RTL; sim only note).
//  - rst_n low mid-run: immediate clear to IDLE, partial results discarded.
// STRUCTURE
//  - Shared package/header: ADD_W default, state encodings IDLE/RUN/DONE (2-bit), NUM_VEC default.
//  - One sub-module: add_ref_model (combinational WIDTH-bit reference adder, WIDTH+1 result),
//    reused later by other checkers; FSM, pipeline and tallies stay in this module.
// TESTING
//  1. rst_n low, start; feed 8 correct vectors (1+4=5, 11+13=24, 15+12=27, 7+6=13, 5+2=7,
//     9+9=18, 0+3=3, 10+8=18) back-to-back -> pass_cnt=8, fail_cnt=0, done=1, all_pass=1.
//  2. Same set, vector 3 out=14 instead of 13 -> fail_cnt=1, pass_cnt=7, first_fail_idx=3,
//     first_fail_vld=1, all_pass=0.
//  3. Carry: a=15,b=12,out=5'd27 passes; out=5'd11 (carry dropped) fails as idx 0 and
//     later failures do not change first_fail_idx.
//  4. in_valid toggled randomly with gaps, plus in_valid=1 pulses in IDLE/DONE -> only 8 counted,
//     in_ready=0 outside RUN and after 8th accept.
//  5. rst_n low after 4 accepts -> all outputs 0 immediately (async), state IDLE, no done.
//  6. start pulsed in DONE and mid-RUN -> tallies clear next edge, fresh 8-vector run completes.

Source files
------------

// File: rtl/add_result_checker_pkg.sv
// Shared definitions for the adder result checker: default widths, run length and FSM encoding.
package add_result_checker_pkg;

    localparam int ADD_W       = 4;
    localparam int NUM_VEC_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/add_result_checker_ref.sv
// Combinational reference adder: WIDTH-bit operands, WIDTH+1-bit sum so the carry is never lost.
module add_ref_model #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   sum
);

    assign sum = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/add_result_checker.sv
// Captures (a, b, out) vectors from the adder path, compares out against a+b one cycle later,
// and keeps pass/fail tallies plus the index of the first mismatch for a run of NUM_VEC vectors.
module add_result_checker
    import add_result_checker_pkg::*;
#(
    parameter int WIDTH   = ADD_W,
    parameter int NUM_VEC = NUM_VEC_DEF,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH:0]   out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             first_fail_vld,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic             all_pass,
    output state_t           dbg_state
);

    // Handshake: a vector transfers on a rising edge where in_valid && in_ready are both high;
    // in_ready never depends on in_valid, and a/b/out need only be stable while in_valid is high.

    localparam logic [CNT_W-1:0] VEC_N = CNT_W'(NUM_VEC);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   acc_idx;
    logic               cmp_vld;
    logic [WIDTH-1:0]   cmp_a, cmp_b;
    logic [WIDTH:0]     cmp_out;
    logic [CNT_W-1:0]   cmp_idx;
    logic [WIDTH:0]     ref_sum;
    logic               accept;

    add_ref_model #(.WIDTH(WIDTH)) u_ref (
        .a   (cmp_a),
        .b   (cmp_b),
        .sum (ref_sum)
    );

    assign in_ready  = (state == RUN) && (acc_idx < VEC_N) && !start;
    assign accept    = in_valid && in_ready;
    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign all_pass  = done && (fail_cnt == '0);
    assign dbg_state = state;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN: begin
                if (start)                             state_nxt = RUN;
                else if (acc_idx == VEC_N && !cmp_vld) state_nxt = DONE;
            end
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // start wins over everything: it clears the run and drops any compare still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_idx        <= '0;
            cmp_vld        <= 1'b0;
            cmp_a          <= '0;
            cmp_b          <= '0;
            cmp_out        <= '0;
            cmp_idx        <= '0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail_vld <= 1'b0;
            first_fail_idx <= '0;
        end else if (start) begin
            acc_idx        <= '0;
            cmp_vld        <= 1'b0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail_vld <= 1'b0;
            first_fail_idx <= '0;
        end else begin
            cmp_vld <= accept;
            if (accept) begin
                cmp_a   <= a;
                cmp_b   <= b;
                cmp_out <= out;
                cmp_idx <= acc_idx;
                acc_idx <= acc_idx + 1'b1;
            end
            if (cmp_vld) begin
                // An unknown out makes the equality unknown, which lands in the fail branch.
                if (cmp_out == ref_sum) begin
                    pass_cnt <= pass_cnt + 1'b1;
                end else begin
                    fail_cnt <= fail_cnt + 1'b1;
                    if (!first_fail_vld) begin
                        first_fail_vld <= 1'b1;
                        first_fail_idx <= cmp_idx;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_add_result_checker.sv
// Directed self-checking bench for add_result_checker: full runs, mismatches, carry, gaps, reset, restart.
module tb_add_result_checker;
    import add_result_checker_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic [4:0] out = '0;
    logic       busy, done, first_fail_vld, all_pass;
    logic [3:0] pass_cnt, fail_cnt, first_fail_idx;
    state_t     dbg_state;

    int n_vec  = 0;
    int n_miss = 0;

    // Hand-computed vector set: a + b = s
    logic [3:0] va [8] = '{4'd1, 4'd11, 4'd15, 4'd7, 4'd5, 4'd9, 4'd0, 4'd10};
    logic [3:0] vb [8] = '{4'd4, 4'd13, 4'd12, 4'd6, 4'd2, 4'd9, 4'd3, 4'd8};
    logic [4:0] vs [8] = '{5'd5, 5'd24, 5'd27, 5'd13, 5'd7, 5'd18, 5'd3, 5'd18};

    add_result_checker dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .a              (a),
        .b              (b),
        .out            (out),
        .busy           (busy),
        .done           (done),
        .pass_cnt       (pass_cnt),
        .fail_cnt       (fail_cnt),
        .first_fail_vld (first_fail_vld),
        .first_fail_idx (first_fail_idx),
        .all_pass       (all_pass),
        .dbg_state      (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // ---------------- driver ----------------
    // Holds the vector until a rising edge sees in_ready; returns 1 time unit after that edge.
    task automatic send_vec(input logic [3:0] ta, input logic [3:0] tb_, input logic [4:0] tout);
        logic rdy;
        a = ta; b = tb_; out = tout; in_valid = 1'b1;
        rdy = 1'b0;
        for (int i = 0; i < 20 && !rdy; i++) begin
            @(negedge clk); rdy = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_vec++;
        if (rdy !== 1'b1) begin n_miss++; $display("FAIL send_timeout: in_ready=%b required 1", rdy); end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done === 1'b1) break;
        end
        n_vec++;
        if (done !== 1'b1) begin n_miss++; $display("FAIL done_timeout: done=%b required 1", done); end
    endtask

    task automatic check_tallies(input string nm, input logic [3:0] ep, input logic [3:0] ef,
                                 input logic ev, input logic [3:0] ei, input logic eap);
        n_vec++;
        if ({pass_cnt, fail_cnt, first_fail_vld, first_fail_idx, all_pass} !== {ep, ef, ev, ei, eap}) begin
            n_miss++;
            $display("FAIL %s: pass=%0d fail=%0d ffv=%b ffi=%0d all_pass=%b required pass=%0d fail=%0d ffv=%b ffi=%0d all_pass=%b",
                     nm, pass_cnt, fail_cnt, first_fail_vld, first_fail_idx, all_pass, ep, ef, ev, ei, eap);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({busy, done, in_ready, pass_cnt, fail_cnt, first_fail_vld, first_fail_idx, all_pass} !== '0
            || dbg_state !== IDLE) begin
            n_miss++; $display("FAIL reset_outputs: busy=%b done=%b rdy=%b pass=%0d fail=%0d state=%0d required all 0",
                               busy, done, in_ready, pass_cnt, fail_cnt, dbg_state);
        end
        @(posedge clk); #1; rst_n = 1'b1;
        // in_valid while IDLE must be ignored
        in_valid = 1'b1; a = 4'd1; b = 4'd1; out = 5'd2;
        repeat (3) begin
            @(negedge clk);
            n_vec++;
            if (in_ready !== 1'b0) begin n_miss++; $display("FAIL idle_ready: in_ready=%b required 0", in_ready); end
        end
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk);
        check_tallies("idle_ignored", 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic test_all_pass();
        pulse_start();
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b1) begin n_miss++; $display("FAIL busy_in_run: busy=%b required 1", busy); end
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) send_vec(va[i], vb[i], vs[i]);
        wait_done();
        check_tallies("all_pass", 4'd8, 4'd0, 1'b0, 4'd0, 1'b1);
        n_vec++;
        if ({busy, in_ready} !== 2'b00) begin n_miss++; $display("FAIL done_idle_flags: busy=%b rdy=%b required 0 0", busy, in_ready); end
    endtask

    task automatic test_one_fail();
        pulse_start();
        for (int i = 0; i < 8; i++) send_vec(va[i], vb[i], (i == 3) ? 5'd14 : vs[i]);
        wait_done();
        check_tallies("one_fail_idx3", 4'd7, 4'd1, 1'b1, 4'd3, 1'b0);
    endtask

    task automatic test_carry();
        pulse_start();
        send_vec(4'd15, 4'd12, 5'd11);   // carry dropped -> fail at idx 0
        send_vec(4'd15, 4'd12, 5'd27);   // carry kept -> pass
        for (int i = 2; i < 8; i++) send_vec(va[i], vb[i], (i == 5) ? 5'd2 : vs[i]);
        wait_done();
        check_tallies("carry_first_fail", 4'd6, 4'd2, 1'b1, 4'd0, 1'b0);
    endtask

    task automatic test_gaps();
        // in_valid during DONE: ignored, previous results held
        in_valid = 1'b1; a = 4'd2; b = 4'd2; out = 5'd4;
        repeat (3) begin
            @(negedge clk);
            n_vec++;
            if (in_ready !== 1'b0) begin n_miss++; $display("FAIL done_ready: in_ready=%b required 0", in_ready); end
        end
        @(posedge clk); #1; in_valid = 1'b0;
        check_tallies("done_hold", 4'd6, 4'd2, 1'b1, 4'd0, 1'b0);
        pulse_start();
        send_vec(va[0], vb[0], vs[0]);
        @(negedge clk);
        check_tallies("latency_edge1", 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
        @(negedge clk);
        check_tallies("latency_edge2", 4'd1, 4'd0, 1'b0, 4'd0, 1'b0);
        for (int i = 1; i < 8; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            send_vec(va[i], vb[i], vs[i]);
        end
        // extra vector offered after the 8th accept must not be taken
        in_valid = 1'b1; a = 4'd3; b = 4'd3; out = 5'd0;
        repeat (3) begin
            @(negedge clk);
            n_vec++;
            if (in_ready !== 1'b0) begin n_miss++; $display("FAIL full_ready: in_ready=%b required 0", in_ready); end
        end
        wait_done();
        @(posedge clk); #1; in_valid = 1'b0;
        check_tallies("gaps_eight_only", 4'd8, 4'd0, 1'b0, 4'd0, 1'b1);
    endtask

    task automatic test_reset_mid();
        pulse_start();
        for (int i = 0; i < 4; i++) send_vec(va[i], vb[i], (i == 1) ? 5'd0 : vs[i]);
        #2; rst_n = 1'b0;
        #1;
        n_vec++;
        if ({busy, done, in_ready, pass_cnt, fail_cnt, first_fail_vld, first_fail_idx, all_pass} !== '0
            || dbg_state !== IDLE) begin
            n_miss++; $display("FAIL async_reset: busy=%b done=%b pass=%0d fail=%0d state=%0d required all 0",
                               busy, done, pass_cnt, fail_cnt, dbg_state);
        end
        @(posedge clk); #1; rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_vec++;
        if ({done, busy} !== 2'b00 || dbg_state !== IDLE) begin
            n_miss++; $display("FAIL post_reset_idle: done=%b busy=%b state=%0d required 0 0 IDLE", done, busy, dbg_state);
        end
    endtask

    task automatic test_restart();
        pulse_start();
        for (int i = 0; i < 8; i++) send_vec(va[i], vb[i], (i == 0) ? 5'd1 : vs[i]);
        wait_done();
        check_tallies("pre_restart", 4'd7, 4'd1, 1'b1, 4'd0, 1'b0);
        pulse_start();
        @(negedge clk);
        n_vec++;
        if ({done, busy} !== 2'b01) begin n_miss++; $display("FAIL restart_from_done: done=%b busy=%b required 0 1", done, busy); end
        check_tallies("restart_clear", 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
        // mid-run restart with a failing vector still in the compare stage
        @(posedge clk); #1;
        send_vec(va[0], vb[0], vs[0]);
        send_vec(va[1], vb[1], 5'd0);
        start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        check_tallies("midrun_restart", 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) send_vec(va[i], vb[i], vs[i]);
        wait_done();
        check_tallies("fresh_run", 4'd8, 4'd0, 1'b0, 4'd0, 1'b1);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_all_pass();
        test_one_fail();
        test_carry();
        test_gaps();
        test_reset_mid();
        test_restart();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
